wb_io_arbiter: RTL and testbench
================================

WB_IO_ARBITER -- requirements
Module: wb_io_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: Wishbone address width.
REQ-002 SHALL have parameter DATA_W, default 32: Wishbone data width; SEL width is DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255: cycles without ACK before an error is raised.
REQ-004 SHALL have port clk, input, 1: single clock; all logic is rising-edge.
REQ-005 SHALL have port reset_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have ports m0_adr/m0_dat_w/m0_sel/m0_we/m0_cyc/m0_stb, inputs, ADDR_W/DATA_W/DATA_W/8/1/1/1: core data master request.
REQ-007 SHALL have ports m0_dat_r/m0_ack/m0_err, outputs, DATA_W/1/1: core master response.
REQ-008 SHALL have ports m1_adr/m1_dat_w/m1_sel/m1_we/m1_cyc/m1_stb, inputs, same widths as m0: debug (JTAG) master request.
REQ-009 SHALL have ports m1_dat_r/m1_ack/m1_err, outputs, same widths as m0: debug master response.
REQ-010 SHALL have ports s_adr/s_dat_w/s_sel/s_we/s_cyc/s_stb, outputs, same widths as m0: IO slave bus (UART/SPI/GPIO/PWM).
REQ-011 SHALL have ports s_dat_r/s_ack, inputs, DATA_W/1: IO slave response.

Function
REQ-012 SHALL implement an FSM with states IDLE, GNT_M0, GNT_M1.
REQ-013 SHALL move IDLE->GNT_Mx at the clock edge where only mx_cyc=1.
REQ-014 SHALL resolve simultaneous m0_cyc=m1_cyc=1 in IDLE round-robin: grant the master not recorded in last_grant.
REQ-015 SHALL hold the grant while the owner's cyc=1; owner cyc=0 -> IDLE next edge; the other master's requests are ignored meanwhile.
REQ-016 SHALL require one IDLE cycle between grants; no back-to-back owner switch.
REQ-017 SHALL drive s_* from the owner's request combinationally in GNT_Mx; in IDLE s_cyc=s_stb=s_we=0 and s_adr/s_dat_w/s_sel=0.
REQ-018 SHALL give first-transfer latency of one cycle: cyc/stb asserted at edge N appear on s_cyc/s_stb after edge N, in the cycle following edge N.
REQ-019 SHALL route s_ack only to the owner's mx_ack; the non-owner ack/err=0.
REQ-020 SHALL broadcast s_dat_r to both m0_dat_r and m1_dat_r; data is valid only with ack.
REQ-021 SHALL update last_grant on each IDLE->GNT_Mx transition.
REQ-022 SHALL support pipelined-classic bursts: multiple stb/ack pairs within one cyc stay with one owner.

Reset
REQ-023 SHALL on reset_n=0 immediately force state=IDLE, last_grant=M1 (M0 wins first tie), timeout counter=0.
REQ-024 SHALL force all s_* and all mx_ack/mx_err outputs to 0 during reset, including mid-transfer, with no ack leaked.

Configuration
REQ-025 SHALL compile the timeout feature only when macro WB_IO_ARB_TIMEOUT_EN is defined.
REQ-026 SHALL with the macro: count cycles with s_stb=1 and s_ack=0; on reaching TIMEOUT_CYC, pulse owner mx_err=1 for one cycle, hold s_stb=0 for that cycle, and clear the counter; the counter also clears on s_ack or on leaving the grant.
REQ-027 SHALL without the macro: have no counter; m0_err=m1_err=0 constantly; a missing ack stalls the bus indefinitely.

Structure
REQ-028 SHALL place the state enum (IDLE/GNT_M0/GNT_M1), master-index type, and the TIMEOUT_CYC default in shared package wb_io_pkg.
REQ-029 SHALL factor the grant decision into sub-module wb_rr_arb2 (2-way round-robin, combinational); the FSM and timeout stay in wb_io_arbiter.
REQ-030 SHALL size the timeout counter as $clog2(TIMEOUT_CYC+1) bits; it saturates and never wraps.

Verification
REQ-031 SHALL test: m0 write adr=0x2000_0000 dat=0xA5 alone, slave acks on its 2nd cycle -> s_* mirror m0 one cycle after cyc; m0_ack=1 once; m1_ack=0.
REQ-032 SHALL test: m0_cyc and m1_cyc rise together after reset -> M0 granted first; after M0 drops cyc, one IDLE cycle, then M1 granted.
REQ-033 SHALL test: M1 holds cyc over a 4-beat burst while m0_cyc=1 -> all 4 acks go to m1; M0 is granted only after m1_cyc=0 plus one IDLE cycle.
REQ-034 SHALL test: with WB_IO_ARB_TIMEOUT_EN and TIMEOUT_CYC=8, slave never acks -> m0_err pulses once exactly 8 cycles after s_stb rose; without the macro, m0_err stays 0.
REQ-035 SHALL test: reset_n pulled low mid-burst (after 2 acks) -> s_cyc/s_stb=0 asynchronously; after release, state=IDLE and the next tie goes to M0.

Source files
------------

// File: rtl/wb_io_pkg.sv
// -----------------------------------------------------------------------------
// wb_io_pkg
// Shared types and defaults for the Wishbone IO arbiter slice.
//   state_e              : arbiter FSM states (IDLE / GNT_M0 / GNT_M1)
//   mst_e                : master index (M0 = core data, M1 = debug/JTAG)
//   TIMEOUT_CYC_DEFAULT  : default ACK timeout in cycles
//   other_mst()          : returns the opposite master index
// -----------------------------------------------------------------------------
package wb_io_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_M0 = 2'd1,
        GNT_M1 = 2'd2
    } state_e;

    typedef enum logic {
        MST_M0 = 1'b0,
        MST_M1 = 1'b1
    } mst_e;

    localparam int unsigned TIMEOUT_CYC_DEFAULT = 255;

    function automatic mst_e other_mst(input mst_e m);
        return (m == MST_M0) ? MST_M1 : MST_M0;
    endfunction

endpackage

// File: rtl/wb_rr_arb2.sv
// -----------------------------------------------------------------------------
// wb_rr_arb2
// Two-way round-robin grant decision, purely combinational.
// Ports:
//   req0_i / req1_i : request from master 0 / master 1
//   last_i          : master that received the previous grant
//   valid_o         : at least one request present
//   gnt_o           : master to grant (meaningful only when valid_o = 1)
// On a tie the master NOT recorded in last_i wins.
// -----------------------------------------------------------------------------
module wb_rr_arb2
    import wb_io_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  mst_e last_i,
    output logic valid_o,
    output mst_e gnt_o
);

    always_comb begin
        valid_o = req0_i | req1_i;
        gnt_o   = MST_M0;
        if (req0_i && req1_i) begin
            gnt_o = other_mst(last_i);
        end else if (req1_i) begin
            gnt_o = MST_M1;
        end
    end

endmodule

// File: rtl/wb_io_arbiter.sv
// -----------------------------------------------------------------------------
// wb_io_arbiter
// Two-master (core M0, debug M1) to one IO slave Wishbone arbiter.
// Grants are held for the whole owner cycle (bursts stay with one owner) and
// one IDLE cycle separates successive grants. Slave signals are a
// combinational mux of the owner's request, so the first transfer appears one
// cycle after cyc is raised (the cycle in which the grant is registered).
// Ports:
//   clk, reset_n                       : clock, async active-low reset
//   m0_adr/dat_w/sel/we/cyc/stb (in)   : core master request
//   m0_dat_r/ack/err (out)             : core master response
//   m1_* (same as m0)                  : debug master request/response
//   s_adr/dat_w/sel/we/cyc/stb (out)   : IO slave request
//   s_dat_r/ack (in)                   : IO slave response
// Build option:
//   WB_IO_ARB_TIMEOUT_EN : enables the ACK timeout (owner err pulse after
//                          TIMEOUT_CYC stalled strobe cycles). Undefined: no
//                          counter, err outputs tied low.
// -----------------------------------------------------------------------------
module wb_io_arbiter
    import wb_io_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                clk,
    input  logic                reset_n,

    input  logic [ADDR_W-1:0]   m0_adr,
    input  logic [DATA_W-1:0]   m0_dat_w,
    input  logic [DATA_W/8-1:0] m0_sel,
    input  logic                m0_we,
    input  logic                m0_cyc,
    input  logic                m0_stb,
    output logic [DATA_W-1:0]   m0_dat_r,
    output logic                m0_ack,
    output logic                m0_err,

    input  logic [ADDR_W-1:0]   m1_adr,
    input  logic [DATA_W-1:0]   m1_dat_w,
    input  logic [DATA_W/8-1:0] m1_sel,
    input  logic                m1_we,
    input  logic                m1_cyc,
    input  logic                m1_stb,
    output logic [DATA_W-1:0]   m1_dat_r,
    output logic                m1_ack,
    output logic                m1_err,

    output logic [ADDR_W-1:0]   s_adr,
    output logic [DATA_W-1:0]   s_dat_w,
    output logic [DATA_W/8-1:0] s_sel,
    output logic                s_we,
    output logic                s_cyc,
    output logic                s_stb,
    input  logic [DATA_W-1:0]   s_dat_r,
    input  logic                s_ack
);

    state_e state_q, state_d;
    mst_e   last_q, last_d;
    logic   arb_valid;
    mst_e   arb_gnt;
    logic   tmo_hit;

    wb_rr_arb2 u_arb (
        .req0_i  (m0_cyc),
        .req1_i  (m1_cyc),
        .last_i  (last_q),
        .valid_o (arb_valid),
        .gnt_o   (arb_gnt)
    );

    // Reset leaves last_q = M1 so that M0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            last_q  <= MST_M1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = (arb_gnt == MST_M0) ? GNT_M0 : GNT_M1;
                    last_d  = arb_gnt;
                end
            end
            GNT_M0:  if (!m0_cyc) state_d = IDLE;
            GNT_M1:  if (!m1_cyc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode only from the asynchronously reset state register, so
    // asserting reset_n forces every slave/ack/err output low immediately.
    always_comb begin
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_we    = 1'b0;
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        m0_ack  = 1'b0;
        m0_err  = 1'b0;
        m1_ack  = 1'b0;
        m1_err  = 1'b0;
        case (state_q)
            GNT_M0: begin
                s_adr   = m0_adr;
                s_dat_w = m0_dat_w;
                s_sel   = m0_sel;
                s_we    = m0_we;
                s_cyc   = m0_cyc;
                s_stb   = m0_stb & ~tmo_hit;
                m0_ack  = s_ack & ~tmo_hit;
                m0_err  = tmo_hit;
            end
            GNT_M1: begin
                s_adr   = m1_adr;
                s_dat_w = m1_dat_w;
                s_sel   = m1_sel;
                s_we    = m1_we;
                s_cyc   = m1_cyc;
                s_stb   = m1_stb & ~tmo_hit;
                m1_ack  = s_ack & ~tmo_hit;
                m1_err  = tmo_hit;
            end
            default: ;
        endcase
    end

    assign m0_dat_r = s_dat_r;
    assign m1_dat_r = s_dat_r;

`ifdef WB_IO_ARB_TIMEOUT_EN
    localparam int unsigned         TMO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0]    TMO_MAX = TMO_W'(TIMEOUT_CYC);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // The hit cycle is the one after the count reaches TIMEOUT_CYC; strobe is
    // masked during it, so the count restarts from zero afterwards.
    assign tmo_hit = (state_q != IDLE) && (tmo_q == TMO_MAX);

    always_comb begin
        tmo_d = tmo_q;
        if ((state_q == IDLE) || (state_d != state_q) || tmo_hit || s_ack) begin
            tmo_d = '0;
        end else if (s_stb && (tmo_q != TMO_MAX)) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

endmodule

// File: tb/tb_wb_io_arbiter.sv
// -----------------------------------------------------------------------------
// tb_wb_io_arbiter
// Directed bench for wb_io_arbiter (TIMEOUT_CYC = 8). Inputs change 1 time
// unit after a rising edge; outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_wb_io_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] m0_adr, m1_adr, s_adr;
    logic [DW-1:0] m0_dat_w, m1_dat_w, s_dat_w;
    logic [SW-1:0] m0_sel, m1_sel, s_sel;
    logic          m0_we, m0_cyc, m0_stb, m1_we, m1_cyc, m1_stb;
    logic [DW-1:0] m0_dat_r, m1_dat_r, s_dat_r;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic          s_we, s_cyc, s_stb, s_ack;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_io_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .m0_adr   (m0_adr),
        .m0_dat_w (m0_dat_w),
        .m0_sel   (m0_sel),
        .m0_we    (m0_we),
        .m0_cyc   (m0_cyc),
        .m0_stb   (m0_stb),
        .m0_dat_r (m0_dat_r),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m1_adr   (m1_adr),
        .m1_dat_w (m1_dat_w),
        .m1_sel   (m1_sel),
        .m1_we    (m1_we),
        .m1_cyc   (m1_cyc),
        .m1_stb   (m1_stb),
        .m1_dat_r (m1_dat_r),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .s_adr    (s_adr),
        .s_dat_w  (s_dat_w),
        .s_sel    (s_sel),
        .s_we     (s_we),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_dat_r  (s_dat_r),
        .s_ack    (s_ack)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        m0_adr = '0; m0_dat_w = '0; m0_sel = '0; m0_we = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        m1_adr = '0; m1_dat_w = '0; m1_sel = '0; m1_we = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        s_dat_r = '0; s_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        clear_inputs();

        // ---- reset state ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_cyc", s_cyc, 0);
        chk("rst_s_stb", s_stb, 0);
        chk("rst_m0_ack", m0_ack, 0);
        chk("rst_m1_ack", m1_ack, 0);
        chk("rst_m0_err", m0_err, 0);
        step();
        reset_n = 1'b1;

        // ---- m0 single write, slave acks on its 2nd cycle ----
        step();
        m0_adr = 32'h2000_0000; m0_dat_w = 32'hA5; m0_sel = 4'hF;
        m0_we = 1'b1; m0_cyc = 1'b1; m0_stb = 1'b1;
        @(negedge clk);
        chk("a_idle_s_cyc", s_cyc, 0);
        chk("a_idle_s_adr", s_adr, 0);
        @(posedge clk);
        @(negedge clk);
        chk("a_s_cyc", s_cyc, 1);
        chk("a_s_stb", s_stb, 1);
        chk("a_s_we", s_we, 1);
        chk("a_s_adr", s_adr, 32'h2000_0000);
        chk("a_s_dat_w", s_dat_w, 32'hA5);
        chk("a_s_sel", s_sel, 4'hF);
        chk("a_m0_ack_wait", m0_ack, 0);
        step();
        s_ack = 1'b1; s_dat_r = 32'h1234_5678;
        @(negedge clk);
        chk("a_m0_ack", m0_ack, 1);
        chk("a_m1_ack", m1_ack, 0);
        chk("a_m0_dat_r", m0_dat_r, 32'h1234_5678);
        chk("a_m1_dat_r", m1_dat_r, 32'h1234_5678);
        step();
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0;
        @(negedge clk);
        chk("a_m0_ack_once", m0_ack, 0);
        chk("a_end_s_cyc", s_cyc, 0);
        repeat (2) step();

        // ---- tie after reset -> M0 first, IDLE gap, then M1 ----
        do_reset();
        m0_adr = 32'h100; m0_cyc = 1'b1; m0_stb = 1'b1;
        m1_adr = 32'h200; m1_cyc = 1'b1; m1_stb = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("b_tie_adr_m0", s_adr, 32'h100);
        step();
        s_ack = 1'b1;
        @(negedge clk);
        chk("b_m0_ack", m0_ack, 1);
        chk("b_m1_ignored", m1_ack, 0);
        step();
        s_ack = 1'b0; m0_cyc = 1'b0; m0_stb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("b_idle_gap_s_cyc", s_cyc, 0);
        chk("b_idle_gap_s_adr", s_adr, 0);
        @(posedge clk);
        @(negedge clk);
        chk("b_m1_s_cyc", s_cyc, 1);
        chk("b_m1_s_adr", s_adr, 32'h200);

        // ---- M1 4-beat burst while M0 requests ----
        m0_cyc = 1'b1; m0_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            m1_adr = 32'h200 + 32'(4 * i);
            s_ack = 1'b1; s_dat_r = 32'hB000 + 32'(i);
            @(negedge clk);
            chk("c_burst_s_adr", s_adr, 32'h200 + 64'(4 * i));
            chk("c_burst_m1_ack", m1_ack, 1);
            chk("c_burst_m0_ack", m0_ack, 0);
        end
        step();
        s_ack = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        @(negedge clk);
        chk("c_drop_s_cyc", s_cyc, 0);
        @(posedge clk);
        @(negedge clk);
        chk("c_idle_gap_s_cyc", s_cyc, 0);
        @(posedge clk);
        @(negedge clk);
        chk("c_m0_granted_adr", s_adr, 32'h100);
        chk("c_m0_granted_cyc", s_cyc, 1);
        step();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        repeat (2) step();

        // ---- reset mid-burst (last grant now M0) ----
        m1_adr = 32'h300; m1_cyc = 1'b1; m1_stb = 1'b1;
        @(posedge clk);
        step();
        s_ack = 1'b1;
        @(negedge clk);
        chk("d_ack1", m1_ack, 1);
        step();
        @(negedge clk);
        chk("d_ack2", m1_ack, 1);
        step();
        #2 reset_n = 1'b0;
        #1;
        chk("d_rst_s_cyc", s_cyc, 0);
        chk("d_rst_s_stb", s_stb, 0);
        chk("d_rst_m1_ack", m1_ack, 0);
        chk("d_rst_m1_err", m1_err, 0);
        m0_cyc = 1'b1; m0_stb = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1; s_ack = 1'b0;
        @(negedge clk);
        chk("d_post_idle_s_cyc", s_cyc, 0);
        @(posedge clk);
        @(negedge clk);
        chk("d_tie_to_m0_adr", s_adr, 32'h100);
        chk("d_tie_to_m0_cyc", s_cyc, 1);
        step();
        m0_cyc = 1'b0; m0_stb = 1'b0; m1_cyc = 1'b0; m1_stb = 1'b0;
        repeat (2) step();

        // ---- slave never acks: timeout behaviour ----
        m0_adr = 32'h400; m0_cyc = 1'b1; m0_stb = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            @(negedge clk);
`ifdef WB_IO_ARB_TIMEOUT_EN
            chk("e_m0_err", m0_err, (k == 9) ? 1 : 0);
            chk("e_s_stb", s_stb, (k == 9) ? 0 : 1);
`else
            chk("e_m0_err", m0_err, 0);
            chk("e_s_stb", s_stb, 1);
`endif
            chk("e_m1_err", m1_err, 0);
        end
        step();
        m0_cyc = 1'b0; m0_stb = 1'b0;
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
